// File: rtl/serial_adder_seq.sv
// serial_adder_seq: multi-cycle WIDTH-bit adder, DIGIT bits per clock, LSB first.
// The carry between digits lives in a flip-flop. A start/done handshake hands
// operands in and results out. The block also reports unsigned carry-out and
// two's-complement overflow.

// One digit slice: DIGIT-bit ripple add with carry in and carry out.
module serial_adder_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);
  logic [DIGIT:0] sum;

  assign sum = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, ci};
  assign s   = sum[DIGIT-1:0];
  assign co  = sum[DIGIT];
endmodule

module serial_adder_seq #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, res;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] dsum;
  logic             dco;
  logic [WIDTH-1:0] res_nxt;
  logic             msb_ci;
  logic             last;

  serial_adder_digit #(.DIGIT(DIGIT)) u_digit (
    .a  (a_sr[DIGIT-1:0]),
    .b  (b_sr[DIGIT-1:0]),
    .ci (carry),
    .s  (dsum),
    .co (dco)
  );

  // The new digit enters the result from the top. After N steps the first
  // digit has reached bit 0. This form also covers DIGIT == WIDTH.
  assign res_nxt = (res >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

  // On the final digit the top bits are the word MSB. The carry into the MSB
  // is recovered from a ^ b ^ sum at that bit.
  assign msb_ci = a_sr[DIGIT-1] ^ b_sr[DIGIT-1] ^ dsum[DIGIT-1];
  assign last   = (cnt == CW'(N - 1));

  // Control FSM and datapath. All outputs are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      z     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> DIGIT;
          b_sr  <= b_sr >> DIGIT;
          res   <= res_nxt;
          carry <= dco;
          cnt   <= cnt + 1'b1;
          if (last) begin
            z     <= res_nxt;
            cout  <= dco;
            ovf   <= msb_ci ^ dco;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
